maxnet_engine: RTL and testbench
================================

MAXNET_ENGINE -- requirements
Module: maxnet_engine

Interface
REQ-001 The block SHALL have parameter N, default 4: channel count, legal range 2..16.
REQ-002 The block SHALL have parameter W, default 5: unsigned channel width in bits.
REQ-003 The block SHALL have parameter K, default 2: inhibition weight eps = 2^-K, legal range 1..W.
REQ-004 The block SHALL have parameter MAX_IT, default 15: maximum update iterations, legal range >= 1.
REQ-005 The block SHALL derive IW = max(1, clog2(N)) internally; IW is not a port.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-008 The block SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-009 The block SHALL have port b_in, input, N*W bits: channel i in bits [i*W +: W]; sampled with start.
REQ-010 The block SHALL have port busy, output, 1 bit: high in ITER and DONE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-012 The block SHALL have port result, output, W bits: original b_in value of the winning channel.
REQ-013 The block SHALL have port winner, output, IW bits: index of the winning channel.
REQ-014 The block SHALL have port none, output, 1 bit: high when all sampled inputs are zero.
REQ-015 The block SHALL have port timeout, output, 1 bit: high when MAX_IT is exhausted without resolution.

Function
REQ-016 The FSM SHALL have states IDLE, ITER and DONE.
REQ-017 In IDLE with start=1, the block SHALL capture b_in into both the B registers (held) and the A registers (working), clear the iteration counter, and go to ITER.
REQ-018 In each ITER cycle, the block SHALL compute S = sum of all A (width W+IW) and cnt = number of nonzero A.
REQ-019 In ITER, if cnt <= 1, the block SHALL register the outputs (REQ-023..REQ-025) and go to DONE; no A update occurs in that cycle.
REQ-020 Else, if the counter equals MAX_IT, the block SHALL set winner = lowest nonzero index, result = B[winner], timeout = 1, and go to DONE.
REQ-021 Otherwise, the block SHALL update every A in parallel: A_i <= sat0(A_i - ((S - A_i) >> K)), where sat0 clamps negative results to 0, and increment the counter.
REQ-022 If that update would leave every A zero while cnt >= 2, the block SHALL instead resolve at once: winner = lowest index nonzero before the update, result = B[winner], then go to DONE.
REQ-023 When cnt = 1, the block SHALL set winner = index of the nonzero A and result = B[winner].
REQ-024 When cnt = 0, the block SHALL set winner = 0, result = 0 and none = 1.
REQ-025 On every resolution, flags not set by that resolution SHALL be 0.
REQ-026 The block SHALL hold done = 1 for exactly the one DONE cycle, then return to IDLE.
REQ-027 result, winner, none and timeout SHALL hold their values until the next accepted start or reset.
REQ-028 The block SHALL ignore start while busy = 1; b_in changes while busy SHALL have no effect.
REQ-029 Latency, in edges from the start-sampling edge to done = 1, SHALL be (update iterations) + 2; the minimum is 2.
REQ-030 With start held high continuously, the block SHALL re-accept it in the IDLE cycle after done.

Reset
REQ-031 rst = 1 SHALL force IDLE on the next edge regardless of state, including mid-ITER.
REQ-032 rst SHALL clear A, B and the counter, and set busy = done = none = timeout = 0, result = 0 and winner = 0.
REQ-033 rst SHALL take priority over start in the same cycle.

Verification (N=4, W=5, K=2, MAX_IT=15)
REQ-034 b = {10,20,5,3} (ch0..ch3) -> iter1 A = {3,16,0,0}, iter2 A = {0,16,0,0}; done 4 edges after start; winner = 1, result = 20, none = timeout = 0.
REQ-035 b = {0,0,0,0} -> done 2 edges after start; none = 1, result = 0, winner = 0.
REQ-036 b = {12,12,0,0} -> A = 9,7,6,5,4,3,3 (stall) -> timeout = 1 after 15 updates; winner = 0, result = 12; done at edge 17.
REQ-037 b = {0,0,7,0} -> no update; winner = 2, result = 7, done 2 edges after start.
REQ-038 Start with b = {10,20,5,3}; assert rst during iter1 -> idle next edge with all outputs zero; a new start with b = {1,2,30,4} then returns winner = 2, result = 30.
REQ-039 Pulse start again while busy, with different b_in -> it is ignored, and the first job's result is unchanged.

Source files
------------

// File: rtl/maxnet_engine.sv
// rtl/maxnet_engine.sv - MAXNET winner-take-all engine with lateral inhibition iterations
module maxnet_engine #(
   parameter int N      = 4,
   parameter int W      = 5,
   parameter int K      = 2,
   parameter int MAX_IT = 15
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic [N*W-1:0]                        b_in,
   output logic                                  busy,
   output logic                                  done,
   output logic [W-1:0]                          result,
   output logic [((N > 2) ? $clog2(N) : 1)-1:0] winner,
   output logic                                  none,
   output logic                                  timeout
);

   localparam int IW = (N > 2) ? $clog2(N) : 1;
   localparam int SW = W + IW;
   localparam int CW = (MAX_IT < 2) ? 1 : $clog2(MAX_IT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ITER,
      S_DONE
   } state_t;

   state_t         state;
   logic [W-1:0]   a [N];
   logic [W-1:0]   b [N];
   logic [CW-1:0]  it_cnt;

   logic [SW-1:0]  sum;
   logic [IW:0]    nz_cnt;
   logic [IW-1:0]  first_nz;
   logic           found;
   logic [W-1:0]   next_a [N];
   logic           all_zero_next;
   logic [SW-1:0]  inhib;

   // Inhibition of channel i is the sum of all other channels scaled by 2^-K;
   // the subtraction saturates at zero instead of wrapping.
   always_comb begin
      sum           = '0;
      nz_cnt        = '0;
      first_nz      = '0;
      found         = 1'b0;
      all_zero_next = 1'b1;
      inhib         = '0;
      for (int i = 0; i < N; i++) begin
         sum = sum + SW'(a[i]);
         if (a[i] != '0) begin
            nz_cnt = nz_cnt + (IW+1)'(1);
            if (!found) begin
               first_nz = IW'(i);
               found    = 1'b1;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         inhib = (sum - SW'(a[i])) >> K;
         if (inhib >= SW'(a[i])) begin
            next_a[i] = '0;
         end else begin
            next_a[i] = a[i] - W'(inhib);
         end
         if (next_a[i] != '0) begin
            all_zero_next = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         it_cnt  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         winner  <= '0;
         none    <= 1'b0;
         timeout <= 1'b0;
         for (int i = 0; i < N; i++) begin
            a[i] <= '0;
            b[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  for (int i = 0; i < N; i++) begin
                     a[i] <= b_in[i*W +: W];
                     b[i] <= b_in[i*W +: W];
                  end
                  it_cnt <= '0;
                  busy   <= 1'b1;
                  state  <= S_ITER;
               end
            end
            S_ITER: begin
               if (nz_cnt <= (IW+1)'(1)) begin
                  // zero or one survivor: resolve without touching A
                  winner  <= (nz_cnt == '0) ? '0 : first_nz;
                  result  <= (nz_cnt == '0) ? '0 : b[first_nz];
                  none    <= (nz_cnt == '0);
                  timeout <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else if (it_cnt == CW'(MAX_IT)) begin
                  winner  <= first_nz;
                  result  <= b[first_nz];
                  none    <= 1'b0;
                  timeout <= 1'b1;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else if (all_zero_next) begin
                  // the update would wipe out every channel; keep the lowest survivor
                  winner  <= first_nz;
                  result  <= b[first_nz];
                  none    <= 1'b0;
                  timeout <= 1'b0;
                  done    <= 1'b1;
                  state   <= S_DONE;
               end else begin
                  for (int i = 0; i < N; i++) begin
                     a[i] <= next_a[i];
                  end
                  it_cnt <= it_cnt + CW'(1);
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_maxnet_engine.sv
// tb/tb_maxnet_engine.sv - randomized self-checking bench for maxnet_engine against a behavioural model
module tb_maxnet_engine;

   localparam int N      = 4;
   localparam int W      = 5;
   localparam int K      = 2;
   localparam int MAX_IT = 15;
   localparam int IW     = 2;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            start = 1'b0;
   logic [N*W-1:0]  b_in = '0;
   logic            busy;
   logic            done;
   logic [W-1:0]    result;
   logic [IW-1:0]   winner;
   logic            none;
   logic            timeout;

   int total = 0;
   int bad = 0;

   maxnet_engine #(.N(N), .W(W), .K(K), .MAX_IT(MAX_IT)) dut (
      .clk(clk), .rst(rst), .start(start), .b_in(b_in), .busy(busy), .done(done),
      .result(result), .winner(winner), .none(none), .timeout(timeout)
   );

   always #5 clk = ~clk;

   function automatic logic [N*W-1:0] pack(input int v[4]);
      logic [N*W-1:0] p;
      p = '0;
      for (int i = 0; i < N; i++) p[i*W +: W] = W'(v[i]);
      return p;
   endfunction

   // Plain-integer MAXNET: iterate the competition rule until at most one channel survives.
   task automatic model(input int bv[4], output int w, output int r, output int nn,
                        output int to, output int upd);
      int a[4];
      int na[4];
      int s, c, f;
      bit fin, allz;
      a = bv; upd = 0; w = 0; r = 0; nn = 0; to = 0; fin = 0;
      while (!fin) begin
         s = 0; c = 0; f = -1;
         for (int i = 0; i < N; i++) begin
            s += a[i];
            if (a[i] > 0) begin
               c++;
               if (f < 0) f = i;
            end
         end
         if (c == 0) begin
            nn = 1; fin = 1;
         end else if (c == 1) begin
            w = f; r = bv[f]; fin = 1;
         end else if (upd == MAX_IT) begin
            w = f; r = bv[f]; to = 1; fin = 1;
         end else begin
            allz = 1;
            for (int i = 0; i < N; i++) begin
               na[i] = a[i] - (s - a[i]) / (1 << K);
               if (na[i] < 0) na[i] = 0;
               if (na[i] != 0) allz = 0;
            end
            if (allz) begin
               w = f; r = bv[f]; fin = 1;
            end else begin
               a = na; upd++;
            end
         end
      end
   endtask

   // Drives one start and returns edges from the sampling edge (edge 1) to done=1.
   task automatic run_job(input int bv[4], output int lat);
      @(negedge clk);
      b_in = pack(bv);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      b_in = '0;
      lat = 1;
      while (!done && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      total++;
      if ({busy, done, none, timeout} !== 4'b0 || result !== '0 || winner !== '0) begin
         bad++;
         $display("FAIL reset_state: busy=%b done=%b none=%b timeout=%b result=%0d winner=%0d required all zero",
                  busy, done, none, timeout, result, winner);
      end
   endtask

   task automatic test_directed;
      int vecs[4][4];
      int exp_w[4], exp_r[4], exp_lat[4], exp_none[4], exp_to[4];
      int lat, mw, mr, mn, mt, mu;
      vecs[0] = '{10, 20, 5, 3};  exp_w[0] = 1; exp_r[0] = 20; exp_lat[0] = 4;  exp_none[0] = 0; exp_to[0] = 0;
      vecs[1] = '{0, 0, 0, 0};    exp_w[1] = 0; exp_r[1] = 0;  exp_lat[1] = 2;  exp_none[1] = 1; exp_to[1] = 0;
      vecs[2] = '{12, 12, 0, 0};  exp_w[2] = 0; exp_r[2] = 12; exp_lat[2] = 17; exp_none[2] = 0; exp_to[2] = 1;
      vecs[3] = '{0, 0, 7, 0};    exp_w[3] = 2; exp_r[3] = 7;  exp_lat[3] = 2;  exp_none[3] = 0; exp_to[3] = 0;
      for (int t = 0; t < 4; t++) begin
         model(vecs[t], mw, mr, mn, mt, mu);
         total++;
         if (mw != exp_w[t] || mr != exp_r[t] || mn != exp_none[t] || mt != exp_to[t] || mu + 2 != exp_lat[t]) begin
            bad++;
            $display("FAIL model_directed%0d: model w=%0d r=%0d none=%0d to=%0d lat=%0d required %0d %0d %0d %0d %0d",
                     t, mw, mr, mn, mt, mu + 2, exp_w[t], exp_r[t], exp_none[t], exp_to[t], exp_lat[t]);
         end
         run_job(vecs[t], lat);
         total++;
         if (lat != exp_lat[t]) begin
            bad++;
            $display("FAIL directed%0d_latency: got %0d required %0d", t, lat, exp_lat[t]);
         end
         total++;
         if (winner !== IW'(exp_w[t]) || result !== W'(exp_r[t]) || none !== 1'(exp_none[t]) ||
             timeout !== 1'(exp_to[t]) || busy !== 1'b1) begin
            bad++;
            $display("FAIL directed%0d_outputs: winner=%0d result=%0d none=%b timeout=%b busy=%b required %0d %0d %0d %0d 1",
                     t, winner, result, none, timeout, busy, exp_w[t], exp_r[t], exp_none[t], exp_to[t]);
         end
         @(negedge clk);
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== W'(exp_r[t]) || winner !== IW'(exp_w[t])) begin
            bad++;
            $display("FAIL directed%0d_after_done: done=%b busy=%b result=%0d winner=%0d required 0 0 %0d %0d",
                     t, done, busy, result, winner, exp_r[t], exp_w[t]);
         end
      end
   endtask

   task automatic test_reset_mid;
      int v1[4];
      int v2[4];
      int lat;
      v1 = '{10, 20, 5, 3};
      v2 = '{1, 2, 30, 4};
      @(negedge clk);
      b_in = pack(v1);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      total++;
      if (busy !== 1'b1) begin
         bad++;
         $display("FAIL reset_mid_busy: got %b required 1", busy);
      end
      rst = 1'b1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      total++;
      if ({busy, done, none, timeout} !== 4'b0 || result !== '0 || winner !== '0) begin
         bad++;
         $display("FAIL reset_mid_clear: busy=%b done=%b none=%b timeout=%b result=%0d winner=%0d required all zero",
                  busy, done, none, timeout, result, winner);
      end
      @(posedge clk);
      @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_priority: busy=%b required 0", busy);
      end
      run_job(v2, lat);
      total++;
      if (winner !== 2'd2 || result !== 5'd30 || none !== 1'b0 || timeout !== 1'b0) begin
         bad++;
         $display("FAIL reset_mid_rerun: winner=%0d result=%0d none=%b timeout=%b required 2 30 0 0",
                  winner, result, none, timeout);
      end
   endtask

   task automatic test_ignore_start;
      int v1[4];
      int v2[4];
      int lat;
      v1 = '{12, 12, 0, 0};
      v2 = '{0, 0, 31, 0};
      @(negedge clk);
      b_in = pack(v1);
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      repeat (3) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      b_in = pack(v2);
      start = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = 1'b0;
      while (!done && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      total++;
      if (lat != 17 || winner !== 2'd0 || result !== 5'd12 || timeout !== 1'b1 || none !== 1'b0) begin
         bad++;
         $display("FAIL ignore_start: lat=%0d winner=%0d result=%0d timeout=%b none=%b required 17 0 12 1 0",
                  lat, winner, result, timeout, none);
      end
      repeat (3) @(negedge clk);
      total++;
      if (busy !== 1'b0 || result !== 5'd12) begin
         bad++;
         $display("FAIL ignore_start_idle: busy=%b result=%0d required 0 12", busy, result);
      end
   endtask

   task automatic test_random;
      int v[4];
      int lat, mw, mr, mn, mt, mu;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            v[i] = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(0, 31));
         end
         model(v, mw, mr, mn, mt, mu);
         run_job(v, lat);
         total++;
         if (lat != mu + 2 || winner !== IW'(mw) || result !== W'(mr) || none !== 1'(mn) || timeout !== 1'(mt)) begin
            bad++;
            $display("FAIL random%0d b=%0d,%0d,%0d,%0d: lat=%0d winner=%0d result=%0d none=%b timeout=%b required %0d %0d %0d %0d %0d",
                     t, v[0], v[1], v[2], v[3], lat, winner, result, none, timeout, mu + 2, mw, mr, mn, mt);
         end
      end
   endtask

   task automatic test_back_to_back;
      int va[4];
      int vb[4];
      int gap, lat, mw, mr, mn, mt, mu;
      va = '{3, 25, 0, 9};
      vb = '{0, 6, 0, 28};
      run_job(va, lat);
      @(negedge clk);
      model(va, mw, mr, mn, mt, mu);
      @(negedge clk);
      b_in = pack(va);
      start = 1'b1;
      lat = 0;
      while (!done && lat < 200) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      total++;
      if (lat != mu + 2 || winner !== IW'(mw) || result !== W'(mr)) begin
         bad++;
         $display("FAIL b2b_first: lat=%0d winner=%0d result=%0d required %0d %0d %0d",
                  lat, winner, result, mu + 2, mw, mr);
      end
      b_in = pack(vb);
      model(vb, mw, mr, mn, mt, mu);
      gap = 0;
      @(posedge clk);
      gap++;
      @(negedge clk);
      while (!done && gap < 200) begin
         @(posedge clk);
         gap++;
         @(negedge clk);
      end
      start = 1'b0;
      total++;
      if (gap != mu + 3 || winner !== IW'(mw) || result !== W'(mr) || none !== 1'(mn) || timeout !== 1'(mt)) begin
         bad++;
         $display("FAIL b2b_second: gap=%0d winner=%0d result=%0d none=%b timeout=%b required %0d %0d %0d %0d %0d",
                  gap, winner, result, none, timeout, mu + 3, mw, mr, mn, mt);
      end
      repeat (2) @(negedge clk);
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_release: busy=%b required 0", busy);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_reset_mid();
      test_ignore_start();
      test_random();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
